// File: rtl/mem_port_sched_if.sv
// rtl/mem_port_sched_if.sv - requester and memory-port signals of the shared memory port scheduler
interface mem_port_sched_if #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic [DATA_W-1:0]         rdata;

  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_ack, mem_rdata,
    output grant, ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_ack, mem_rdata,
    input  grant, ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - round-robin owner of the single memory port with per-transaction timeout
module mem_port_sched #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_port_sched_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      scan;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Scan last+1 .. last+NUM_REQ (wrapping) and take the first pending request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    scan      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = {1'b0, last_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ))
        scan = scan - (IDX_W+1)'(NUM_REQ);
      if (!win_found && bus.req[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
  end

  // Command source: the new winner while idle, the current owner while busy.
  assign sel_idx = (state_q == IDLE) ? win_idx : owner_q;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    ack_d       = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d     = NUM_REQ'(1) << win_idx;
          mem_req_d   = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          last_d      = win_idx;
          owner_d     = win_idx;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          ack_d   = NUM_REQ'(1) << owner_q;
          rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This cycle is the last of TIMEOUT cycles with mem_req high.
          ack_d   = NUM_REQ'(1) << owner_q;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          grant_d     = grant_q;
          mem_req_d   = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
